// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
//   Bundles the two cache-controller request channels (c0 = I-cache,
//   c1 = D-cache) and the shared main-memory request channel that the
//   arbiter sits between.
//
//   Port/cache channel (per port cN):
//     cN_req_valid/rw/addr/wdata : request, held stable by the cache until ready
//     cN_req_ready               : one-cycle completion pulse
//     cN_req_rdata               : read line, valid with ready
//     cN_req_err                 : timeout abort flag, pulses with ready
//   Memory channel:
//     mem_req_valid/rw/addr/dataout : request towards memory
//     mem_req_datain                : read line from memory
//     mem_req_ready                 : one-cycle memory completion
//
//   Modports:
//     master : the environment (cache controllers + memory model)
//     slave  : the arbiter
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic              c0_req_valid;
    logic              c0_req_rw;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [DATA_W-1:0] c0_req_wdata;
    logic              c0_req_ready;
    logic [DATA_W-1:0] c0_req_rdata;
    logic              c0_req_err;

    logic              c1_req_valid;
    logic              c1_req_rw;
    logic [ADDR_W-1:0] c1_req_addr;
    logic [DATA_W-1:0] c1_req_wdata;
    logic              c1_req_ready;
    logic [DATA_W-1:0] c1_req_rdata;
    logic              c1_req_err;

    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_dataout;
    logic [DATA_W-1:0] mem_req_datain;
    logic              mem_req_ready;

    modport master (
        output c0_req_valid, c0_req_rw, c0_req_addr, c0_req_wdata,
        input  c0_req_ready, c0_req_rdata, c0_req_err,
        output c1_req_valid, c1_req_rw, c1_req_addr, c1_req_wdata,
        input  c1_req_ready, c1_req_rdata, c1_req_err,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_dataout,
        output mem_req_datain, mem_req_ready
    );

    modport slave (
        input  c0_req_valid, c0_req_rw, c0_req_addr, c0_req_wdata,
        output c0_req_ready, c0_req_rdata, c0_req_err,
        input  c1_req_valid, c1_req_rw, c1_req_addr, c1_req_wdata,
        output c1_req_ready, c1_req_rdata, c1_req_err,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_dataout,
        input  mem_req_datain, mem_req_ready
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//   Shares one main-memory request channel between two cache controllers.
//   Each line transfer walks IDLE -> BUSY -> RESP. Ties in IDLE are broken by
//   a round-robin pointer that moves to the other port after every response.
//   A watchdog aborts a BUSY transfer that sees no mem_req_ready for
//   TIMEOUT_CYC cycles (TIMEOUT_CYC = 0 disables it).
//
//   Ports:
//     clk         : clock, rising edge
//     rst         : synchronous active-high reset
//     bus         : cache_mem_arbiter_if.slave (c0/c1 request channels + memory)
//     busy        : FSM not in IDLE
//     grant_id    : port currently or last served (0 = c0, 1 = c1)
//     timeout_err : sticky watchdog abort flag, cleared only by rst
//   All outputs are registered.
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_mem_arbiter_if.slave      bus,
    output logic                    busy,
    output logic                    grant_id,
    output logic                    timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit WD_EN = (TIMEOUT_CYC != 0);
    // Abort fires in the BUSY cycle whose counter equals TIMEOUT_CYC-1, so
    // mem_req_valid is high for exactly TIMEOUT_CYC cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              grant_s;
    logic              grant_port_s;
    logic              done_s;
    logic              abort_s;

    logic              ptr_r;
    logic              grant_id_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              timeout_err_r;

    logic              mem_valid_r;
    logic              mem_rw_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic              c0_ready_r;
    logic              c0_err_r;
    logic [DATA_W-1:0] c0_rdata_r;
    logic              c1_ready_r;
    logic              c1_err_r;
    logic [DATA_W-1:0] c1_rdata_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_port_s = ptr_r;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.c0_req_valid && bus.c1_req_valid) begin
                    grant_s      = 1'b1;
                    grant_port_s = ptr_r;
                    state_next_s = ST_BUSY;
                end else if (bus.c0_req_valid) begin
                    grant_s      = 1'b1;
                    grant_port_s = 1'b0;
                    state_next_s = ST_BUSY;
                end else if (bus.c1_req_valid) begin
                    grant_s      = 1'b1;
                    grant_port_s = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A memory completion in the expiry cycle wins over the abort.
                if (bus.mem_req_ready) begin
                    done_s       = 1'b1;
                    state_next_s = ST_RESP;
                end else if (WD_EN && (cnt_r == CNT_LAST)) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered datapath: memory request fields, port responses, watchdog, pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r         <= 1'b0;
            grant_id_r    <= 1'b0;
            cnt_r         <= '0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            mem_valid_r   <= 1'b0;
            mem_rw_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            c0_ready_r    <= 1'b0;
            c0_err_r      <= 1'b0;
            c0_rdata_r    <= '0;
            c1_ready_r    <= 1'b0;
            c1_err_r      <= 1'b0;
            c1_rdata_r    <= '0;
        end else begin
            c0_ready_r <= 1'b0;
            c0_err_r   <= 1'b0;
            c1_ready_r <= 1'b0;
            c1_err_r   <= 1'b0;
            busy_r     <= (state_next_s != ST_IDLE);

            if (grant_s) begin
                grant_id_r  <= grant_port_s;
                cnt_r       <= '0;
                mem_valid_r <= 1'b1;
                mem_rw_r    <= grant_port_s ? bus.c1_req_rw    : bus.c0_req_rw;
                mem_addr_r  <= grant_port_s ? bus.c1_req_addr  : bus.c0_req_addr;
                mem_wdata_r <= grant_port_s ? bus.c1_req_wdata : bus.c0_req_wdata;
            end else if (done_s || abort_s) begin
                // Response is registered here so the ready pulse lands in RESP.
                mem_valid_r <= 1'b0;
                if (grant_id_r) begin
                    c1_ready_r <= 1'b1;
                    c1_err_r   <= abort_s;
                    c1_rdata_r <= done_s ? bus.mem_req_datain : '0;
                end else begin
                    c0_ready_r <= 1'b1;
                    c0_err_r   <= abort_s;
                    c0_rdata_r <= done_s ? bus.mem_req_datain : '0;
                end
                if (abort_s) begin
                    timeout_err_r <= 1'b1;
                end
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            if (state_r == ST_RESP) begin
                ptr_r <= ~grant_id_r;
            end
        end
    end

    assign bus.mem_req_valid   = mem_valid_r;
    assign bus.mem_req_rw      = mem_rw_r;
    assign bus.mem_req_addr    = mem_addr_r;
    assign bus.mem_req_dataout = mem_wdata_r;
    assign bus.c0_req_ready    = c0_ready_r;
    assign bus.c0_req_err      = c0_err_r;
    assign bus.c0_req_rdata    = c0_rdata_r;
    assign bus.c1_req_ready    = c1_ready_r;
    assign bus.c1_req_err      = c1_err_r;
    assign bus.c1_req_rdata    = c1_rdata_r;
    assign busy                = busy_r;
    assign grant_id            = grant_id_r;
    assign timeout_err         = timeout_err_r;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Two-port arbiter that shares the single main-memory request interface between two cache controllers, port c0 (I-cache) and port c1 (D-cache). It sits between the cache controllers' mem_req_* side and the memory model or controller. Each line transfer is serialised through a 3-state FSM with round-robin fairness. A watchdog aborts memory transactions that never complete.

Parameters:
ADDR_W, 32, address width
DATA_W, 128, cache-line data width
TIMEOUT_CYC, 64, BUSY cycles with mem_req_ready low before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
c0_req_valid  in  1  port 0 request
c0_req_rw  in  1  1=write, 0=read
c0_req_addr  in  ADDR_W  line address
c0_req_wdata  in  DATA_W  write line
c0_req_ready  out  1  one-cycle completion pulse
c0_req_rdata  out  DATA_W  read line, valid with ready
c0_req_err  out  1  timeout abort, pulses with ready
c1_req_valid, c1_req_rw, c1_req_addr, c1_req_wdata, c1_req_ready, c1_req_rdata, c1_req_err  same as c0
mem_req_valid  out  1  memory request
mem_req_rw  out  1  1=write
mem_req_addr  out  ADDR_W  latched address
mem_req_dataout  out  DATA_W  latched write data to memory
mem_req_datain  in  DATA_W  read data from memory
mem_req_ready  in  1  memory completion, one cycle
busy  out  1  FSM not IDLE
grant_id  out  1  port currently or last served
timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset: all outputs 0, FSM=IDLE, priority pointer=c0, watchdog counter=0, timeout_err=0. Reset dominates in any state. An in-flight transaction is dropped: no ready pulse, mem_req_valid low the cycle after rst is sampled.
- Requester rule: a port holds valid, rw, addr and wdata stable until its ready pulse. Valid seen in the cycle after ready is treated as a new request.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no valid: stay in IDLE.
- IDLE, one port valid: grant that port.
- IDLE, both ports valid: grant the port named by the priority pointer.
- On a grant: latch the port's rw, addr and wdata into the mem_req_* registers, set grant_id, clear the counter, go to BUSY.
- IDLE at cycle t with valid → mem_req_valid=1 at t+1.
- BUSY: mem_req_valid=1 with the latched fields held stable.
- BUSY, mem_req_ready=1 at cycle u: latch mem_req_datain into the granted port's rdata (writes latch it too, so rdata is don't-care for writes). Drop mem_req_valid at u+1. Go to RESP.
- BUSY, mem_req_ready=0: counter increments.
- Watchdog: if TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 with ready still low, abort. Abort sets rdata=0, arms err, sets timeout_err=1 and goes to RESP.
- If mem_req_ready arrives in the same cycle the counter expires, ready wins: normal completion, no error.
- RESP (one cycle): granted port's ready=1 (plus err on abort); other port's outputs stay 0. Pointer moves to the other port. Next state IDLE.
- Completion latency: memory ready at u → port ready at u+1 → IDLE at u+2. Minimum back-to-back spacing is 4 cycles per transfer when memory answers in 1 cycle.
- Round-robin: a port that was just served loses any tie at the next arbitration. A lone requester is served every time regardless of the pointer.
- Valid toggling while not granted is ignored; there is no latching until grant.
- rdata registers hold their last value until the next completion for that port.

Test Plan:
- Single read: c0 read addr 0x100, memory answers datain=0xA5A5…A5 three cycles after mem_req_valid → mem_req_addr=0x100, mem_req_rw=0; c0_req_ready pulses one cycle with that rdata; c1 outputs stay 0; busy falls 2 cycles after mem ready.
- Contention: c0 and c1 both valid from reset release, each holding four requests → mem grants alternate c0, c1, c0, c1…; grant_id toggles; no port is served twice in a row while the other waits.
- Write: c1 write addr 0x2040, wdata=0xDEADBEEF… → mem_req_rw=1 and mem_req_dataout=wdata, held stable until mem_req_ready; c1_req_ready pulses once.
- Timeout: TIMEOUT_CYC=8, memory never ready → mem_req_valid high exactly 8 cycles then low; c0_req_ready=1 with c0_req_err=1 and rdata=0; timeout_err stays 1 over later good transfers until rst.
- Ready at expiry: mem_req_ready asserted in the 8th BUSY cycle with TIMEOUT_CYC=8 → normal completion with real data, err=0, timeout_err=0.
- Reset mid-BUSY: assert rst for one cycle during an outstanding read → next cycle mem_req_valid=0, busy=0, no ready pulse; a subsequent c1 request is granted first (pointer reset to c0 but c0 idle).
